// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: streams a program image into instruction memory, then releases the core.
// The core stays halted while loading and for one flush cycle after the last write.
module imem_load_ctrl #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_load_start,
   input  logic [AW:0]   i_load_len,
   input  logic          i_load_valid,
   input  logic [31:0]   i_load_data,
   output logic          o_load_ready,
   input  logic          i_run_start,
   input  logic [63:0]   i_fetch_pc,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_waddr,
   output logic [31:0]   o_mem_wdata,
   output logic [AW-1:0] o_mem_raddr,
   output logic          o_core_halt,
   output logic          o_load_done,
   output logic          o_fetch_misaligned,
   output logic          o_load_err
);
   typedef enum logic [1:0] {HALT, LOAD, FLUSH, RUN} state_t;
   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
   state_t        r_state;
   logic [AW-1:0] r_ptr;
   logic [AW:0]   r_cnt;
   logic          r_err;
   logic          w_len_ok;
   logic          w_xfer;
   logic          w_last;
   logic          w_unused_pc;
   assign w_len_ok           = (i_load_len != '0) && (i_load_len <= LP_DEPTH);
   assign w_xfer             = (r_state == LOAD) && i_load_valid;
   assign w_last             = r_cnt == (AW+1)'(1);
   assign o_load_ready       = r_state == LOAD;
   assign o_core_halt        = r_state != RUN;
   assign o_mem_we           = w_xfer;
   assign o_mem_waddr        = r_ptr;
   assign o_mem_wdata        = i_load_data;
   assign o_load_done        = w_xfer && w_last;
   assign o_mem_raddr        = i_fetch_pc[AW+1:2];
   assign o_fetch_misaligned = (r_state == RUN) && (i_fetch_pc[1:0] != 2'b00);
   assign o_load_err         = r_err;
   // high address bits wrap away; only the word index and alignment bits matter
   assign w_unused_pc        = ^i_fetch_pc[63:AW+2];
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= HALT;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            HALT, RUN: begin
               if (i_load_start && w_len_ok) begin
                  r_state <= LOAD;
                  r_ptr   <= '0;
                  r_cnt   <= i_load_len;
               end else if (i_load_start) begin
                  r_err <= 1'b1;
               end else if (i_run_start) begin
                  r_state <= RUN;
               end
            end
            LOAD: begin
               if (w_xfer) begin
                  r_ptr <= r_ptr + AW'(1);
                  r_cnt <= r_cnt - (AW+1)'(1);
                  if (w_last) r_state <= FLUSH;
               end
            end
            FLUSH:   r_state <= RUN;
            default: r_state <= HALT;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl: directed checks of load, flush, run, error and reset behaviour.
module tb_imem_load_ctrl;
   localparam int AW = 8;
   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          load_start = 1'b0;
   logic [AW:0]   load_len = '0;
   logic          load_valid = 1'b0;
   logic [31:0]   load_data = '0;
   logic          run_start = 1'b0;
   logic [63:0]   fetch_pc = '0;
   logic          load_ready, mem_we, core_halt, load_done, fetch_misaligned, load_err;
   logic [AW-1:0] mem_waddr, mem_raddr;
   logic [31:0]   mem_wdata;
   logic [31:0]   tb_mem [256];
   int            wr_cnt = 0;
   int            wr_snap;
   int            n_chk = 0;
   int            n_pass = 0;

   imem_load_ctrl #(.DEPTH(256), .AW(AW)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_load_start(load_start), .i_load_len(load_len),
      .i_load_valid(load_valid), .i_load_data(load_data), .o_load_ready(load_ready),
      .i_run_start(run_start), .i_fetch_pc(fetch_pc), .o_mem_we(mem_we),
      .o_mem_waddr(mem_waddr), .o_mem_wdata(mem_wdata), .o_mem_raddr(mem_raddr),
      .o_core_halt(core_halt), .o_load_done(load_done),
      .o_fetch_misaligned(fetch_misaligned), .o_load_err(load_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we === 1'b1) begin
         tb_mem[mem_waddr] = mem_wdata;
         wr_cnt++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) tb_mem[i] = '0;
      @(negedge clk); #1;
      check("rst_halt", core_halt, 1);
      check("rst_ready", load_ready, 0);
      check("rst_we", mem_we, 0);
      check("rst_done", load_done, 0);
      check("rst_err", load_err, 0);
      @(negedge clk) rstn = 1'b1;

      // three back-to-back words
      @(negedge clk) begin load_start = 1'b1; load_len = 9'd3; end
      #1 check("halt_ready", load_ready, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk) begin load_start = 1'b0; load_valid = 1'b1; load_data = 32'hA0 + i; end
         #1;
         check("l3_we", mem_we, 1);
         check("l3_addr", mem_waddr, i);
         check("l3_wdata", mem_wdata, 32'hA0 + i);
         check("l3_done", load_done, i == 2);
      end
      @(negedge clk) load_valid = 1'b0;
      #1;
      check("flush_halt", core_halt, 1);
      check("flush_ready", load_ready, 0);
      check("flush_we", mem_we, 0);
      @(negedge clk); #1;
      check("run_halt", core_halt, 0);
      check("l3_mem2", tb_mem[2], 32'hA2);
      check("l3_wrcnt", wr_cnt, 3);

      // fetch address decode in RUN
      fetch_pc = 64'h0000_0000_0000_0406; #1;
      check("mis_raddr", mem_raddr, 8'h01);
      check("mis_flag", fetch_misaligned, 1);
      fetch_pc = 64'hFFFF_0000_0000_07FC; #1;
      check("wrap_raddr", mem_raddr, 8'hFF);
      check("wrap_mis", fetch_misaligned, 0);

      // gapped load from RUN, with ignored start requests during the gap
      wr_snap = wr_cnt;
      @(negedge clk) begin load_start = 1'b1; load_len = 9'd2; end
      @(negedge clk) begin load_start = 1'b0; load_valid = 1'b1; load_data = 32'hD0; end
      #1;
      check("gap_halt", core_halt, 1);
      check("gap_addr0", mem_waddr, 0);
      check("gap_mis_halted", fetch_misaligned, 0);
      @(negedge clk) begin load_valid = 1'b0; run_start = 1'b1; load_start = 1'b1; load_len = 9'd5; end
      #1 check("gap_we1", mem_we, 0);
      @(negedge clk) begin run_start = 1'b0; load_start = 1'b0; end
      #1;
      check("gap_we2", mem_we, 0);
      check("gap_ready", load_ready, 1);
      @(negedge clk) begin load_valid = 1'b1; load_data = 32'hD1; end
      #1;
      check("gap_addr1", mem_waddr, 1);
      check("gap_done", load_done, 1);
      @(negedge clk) load_valid = 1'b0;
      @(negedge clk); #1;
      check("gap_run", core_halt, 0);
      check("gap_wrcnt", wr_cnt - wr_snap, 2);

      // illegal length zero while running
      wr_snap = wr_cnt;
      @(negedge clk) begin load_start = 1'b1; load_len = 9'd0; end
      #1 check("len0_we", mem_we, 0);
      @(negedge clk) load_start = 1'b0;
      #1;
      check("len0_err", load_err, 1);
      check("len0_run", core_halt, 0);
      check("len0_ready", load_ready, 0);

      // illegal length 257 from a fresh HALT, then start+run together
      @(negedge clk) rstn = 1'b0;
      #1 check("rst_err_clr", load_err, 0);
      @(negedge clk) rstn = 1'b1;
      @(negedge clk) begin load_start = 1'b1; load_len = 9'd257; end
      #1 check("len257_we", mem_we, 0);
      @(negedge clk) load_start = 1'b0;
      #1;
      check("len257_err", load_err, 1);
      check("len257_halt", core_halt, 1);
      check("len257_ready", load_ready, 0);
      check("bad_wrcnt", wr_cnt - wr_snap, 0);
      @(negedge clk) begin load_start = 1'b1; run_start = 1'b1; load_len = 9'd1; end
      @(negedge clk) begin load_start = 1'b0; run_start = 1'b0; end
      #1 check("both_load", load_ready, 1);
      @(negedge clk) begin load_valid = 1'b1; load_data = 32'hF0; end
      #1 check("both_done", load_done, 1);
      @(negedge clk) load_valid = 1'b0;
      @(negedge clk);

      // full-depth load
      wr_snap = wr_cnt;
      @(negedge clk) begin load_start = 1'b1; load_len = 9'd256; end
      for (int i = 0; i < 256; i++) begin
         @(negedge clk) begin load_start = 1'b0; load_valid = 1'b1; load_data = 32'hC0DE_0000 + i; end
         #1;
         check("full_addr", mem_waddr, i);
         if (i == 254 || i == 255) check("full_done", load_done, i == 255);
      end
      @(negedge clk) load_valid = 1'b1;
      #1 check("full_flush_we", mem_we, 0);
      @(negedge clk); #1;
      check("full_run", core_halt, 0);
      check("full_we_run", mem_we, 0);
      check("full_mem0", tb_mem[0], 32'hC0DE_0000);
      check("full_mem255", tb_mem[255], 32'hC0DE_00FF);
      check("full_wrcnt", wr_cnt - wr_snap, 256);

      // reset in the middle of a ten-word load
      @(negedge clk) begin load_start = 1'b1; load_len = 9'd10; load_valid = 1'b0; end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk) begin load_start = 1'b0; load_valid = 1'b1; load_data = 32'hAA00_0000 + i; end
      end
      @(negedge clk) begin rstn = 1'b0; load_data = 32'hBAD0_0000; end
      #1;
      check("mid_rst_we", mem_we, 0);
      check("mid_rst_ready", load_ready, 0);
      check("mid_rst_halt", core_halt, 1);
      check("mid_rst_done", load_done, 0);
      @(negedge clk) rstn = 1'b1;
      #1;
      check("post_rst_halt", core_halt, 1);
      check("post_rst_ready", load_ready, 0);
      wr_snap = wr_cnt;
      @(negedge clk) run_start = 1'b1;
      @(negedge clk) run_start = 1'b0;
      #1;
      check("post_rst_run", core_halt, 0);
      check("post_rst_we", mem_we, 0);
      @(negedge clk); @(negedge clk);
      load_valid = 1'b0;
      check("post_rst_wrcnt", wr_cnt - wr_snap, 0);
      check("part_mem4", tb_mem[4], 32'hAA00_0004);
      check("part_mem5", tb_mem[5], 32'hC0DE_0005);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
